weight_fetch_sequencer: RTL

- Sequences filter-weight reads from the weight memory into the weight capture register that feeds the systolic array.
- Fetches a contiguous run of weight words per round, for a programmed number of rounds.
- Tags each returned word with its index and signals the array controller when a round is fully loaded.
- Sits between the SA controller (start / next-round requests) and the weight memory plus its capture register (address, read-load).

---
 rtl/weight_fetch_sequencer_pkg.sv | 25 ++
 rtl/weight_fetch_sequencer_if.sv | 39 +++
 rtl/weight_fetch_sequencer_valid_pipe.sv | 44 ++++
 rtl/weight_fetch_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/weight_fetch_sequencer_pkg.sv
// Shared definitions for the weight fetch sequencer: state encoding,
// default widths and the legal read-latency range of the weight memory.
package weight_fetch_sequencer_pkg;

    localparam int ADDR_WIDTH_DEF          = 16;
    localparam int WORDS_WIDTH_DEF         = 4;
    localparam int COUNTER_ROUND_WIDTH_DEF = 3;

    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT_NEXT,
        DONE
    } wfs_state_e;

    // The capture register only exists for 1..3 cycles of read latency.
    function automatic bit mem_latency_ok(input int latency);
        return (latency >= MEM_LATENCY_MIN) && (latency <= MEM_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/weight_fetch_sequencer_if.sv
// Bundle of the SA-controller and weight-memory side signals of the
// sequencer. The controller (master) issues jobs, the sequencer (slave)
// drives the memory address, read-load and the returned-word tags.
interface weight_fetch_sequencer_if
#(
    parameter int ADDR_WIDTH          = weight_fetch_sequencer_pkg::ADDR_WIDTH_DEF,
    parameter int WORDS_WIDTH         = weight_fetch_sequencer_pkg::WORDS_WIDTH_DEF,
    parameter int COUNTER_ROUND_WIDTH = weight_fetch_sequencer_pkg::COUNTER_ROUND_WIDTH_DEF
);

    logic                           start_i;
    logic                           abort_i;
    logic [ADDR_WIDTH-1:0]          base_addr_i;
    logic [WORDS_WIDTH-1:0]         words_per_round_i;
    logic [COUNTER_ROUND_WIDTH-1:0] max_round_i;
    logic                           next_round_i;

    logic [ADDR_WIDTH-1:0]          weight_addr_o;
    logic                           rd_weight_ld_o;
    logic                           weight_valid_o;
    logic [WORDS_WIDTH-1:0]         word_idx_o;
    logic [COUNTER_ROUND_WIDTH-1:0] round_o;
    logic                           round_loaded_o;
    logic                           busy_o;
    logic                           done_o;

    modport master (
        output start_i, abort_i, base_addr_i, words_per_round_i, max_round_i, next_round_i,
        input  weight_addr_o, rd_weight_ld_o, weight_valid_o, word_idx_o, round_o,
               round_loaded_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, base_addr_i, words_per_round_i, max_round_i, next_round_i,
        output weight_addr_o, rd_weight_ld_o, weight_valid_o, word_idx_o, round_o,
               round_loaded_o, busy_o, done_o
    );

endinterface

// File: rtl/weight_fetch_sequencer_valid_pipe.sv
// Shift register that follows each issued read through the memory latency,
// so the word index arrives together with the data in the capture register.
module weight_valid_pipe
    import weight_fetch_sequencer_pkg::*;
#(
    parameter int DEPTH     = 1,
    parameter int IDX_WIDTH = WORDS_WIDTH_DEF
)
(
    input  logic                 clk_i,
    input  logic                 rd_weight_rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [IDX_WIDTH-1:0] in_idx,
    output logic                 out_valid,
    output logic [IDX_WIDTH-1:0] out_idx,
    output logic                 any_valid
);

    logic [DEPTH-1:0]                valid_q;
    logic [DEPTH-1:0][IDX_WIDTH-1:0] idx_q;

    // Shift {valid, idx} one stage per cycle; a flush drops every word in flight.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            idx_q[0]   <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_idx   = idx_q[DEPTH-1];
    assign any_valid = |valid_q;

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Issues contiguous weight-memory reads, one run of words per round, for a
// programmed number of rounds, and tags each returned word with its index.
module weight_fetch_sequencer
    import weight_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH          = ADDR_WIDTH_DEF,
    parameter int WORDS_WIDTH         = WORDS_WIDTH_DEF,
    parameter int COUNTER_ROUND_WIDTH = COUNTER_ROUND_WIDTH_DEF,
    parameter int MEM_LATENCY         = 1
)
(
    input  logic                     clk_i,
    input  logic                     rd_weight_rst,
    weight_fetch_sequencer_if.slave  bus
);

    if (!mem_latency_ok(MEM_LATENCY)) begin : g_bad_mem_latency
        $error("weight_fetch_sequencer: MEM_LATENCY must be 1..3");
    end

    wfs_state_e                     state_q;
    wfs_state_e                     state_d;
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [WORDS_WIDTH-1:0]         word_cnt_q;
    logic [WORDS_WIDTH-1:0]         words_lat_q;
    logic [COUNTER_ROUND_WIDTH-1:0] max_round_lat_q;
    logic [COUNTER_ROUND_WIDTH-1:0] round_q;
    logic                           rd_ld;
    logic                           done;
    logic                           pipe_valid;
    logic [WORDS_WIDTH-1:0]         pipe_idx;
    logic                           pipe_busy;
    logic                           last_word;

    assign last_word = (word_cnt_q == words_lat_q - WORDS_WIDTH'(1));

    // State register.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and read/done strobes; abort overrides everything, including a start in IDLE.
    always_comb begin
        state_d = state_q;
        rd_ld   = 1'b0;
        done    = 1'b0;
        if (bus.abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    rd_ld = 1'b1;
                    if (last_word) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state_d = (round_q == max_round_lat_q) ? DONE : WAIT_NEXT;
                    end
                end
                WAIT_NEXT: begin
                    if (bus.next_round_i) begin
                        state_d = FETCH;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Job configuration, read address, word counter and round index; the address is never rewound between rounds.
    always_ff @(posedge clk_i or posedge rd_weight_rst) begin
        if (rd_weight_rst) begin
            addr_q          <= '0;
            word_cnt_q      <= '0;
            words_lat_q     <= '0;
            max_round_lat_q <= '0;
            round_q         <= '0;
        end else if (!bus.abort_i) begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        addr_q          <= bus.base_addr_i;
                        word_cnt_q      <= '0;
                        words_lat_q     <= (bus.words_per_round_i == '0) ? WORDS_WIDTH'(1)
                                                                         : bus.words_per_round_i;
                        max_round_lat_q <= bus.max_round_i;
                        round_q         <= '0;
                    end
                end
                FETCH: begin
                    addr_q     <= addr_q + ADDR_WIDTH'(1);
                    word_cnt_q <= word_cnt_q + WORDS_WIDTH'(1);
                end
                WAIT_NEXT: begin
                    if (bus.next_round_i) begin
                        round_q    <= round_q + COUNTER_ROUND_WIDTH'(1);
                        word_cnt_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    weight_valid_pipe #(
        .DEPTH     (MEM_LATENCY),
        .IDX_WIDTH (WORDS_WIDTH)
    ) u_valid_pipe (
        .clk_i         (clk_i),
        .rd_weight_rst (rd_weight_rst),
        .flush         (bus.abort_i),
        .in_valid      (rd_ld),
        .in_idx        (word_cnt_q),
        .out_valid     (pipe_valid),
        .out_idx       (pipe_idx),
        .any_valid     (pipe_busy)
    );

    assign bus.weight_addr_o  = addr_q;
    assign bus.rd_weight_ld_o = rd_ld;
    assign bus.weight_valid_o = pipe_valid;
    assign bus.word_idx_o     = pipe_idx;
    assign bus.round_o        = round_q;
    assign bus.round_loaded_o = pipe_valid && (pipe_idx == words_lat_q - WORDS_WIDTH'(1));
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.done_o         = done;

endmodule
